// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_port_arbiter: FSM states, grant identifiers and
// the width of the memory-latency wait counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_LS    = 1'b1;

  // Enough for MEM_LATENCY-1 with MEM_LATENCY up to 7.
  localparam int LAT_BITS = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// CPU fetch port and the load/store port, one access at a time.
// Build option: define MEM_ARB_RR_EN to break fetch/load-store ties by
// round-robin on last_grant; otherwise load/store always wins a tie.
//
// Handshake (both CPU ports): the requester raises req with stable
// addr/write/wdata and holds them until its one-cycle valid pulse. Requests
// are sampled only in IDLE; the captured values are used for the whole
// transaction. cpu_stall is high while any request is still unanswered.
// The FSM state is the internal signal 'state' (arb_state_t) for checkers.
module mem_port_arbiter #(
  parameter int WIDTH       = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] fetch_addr,
  output logic [WIDTH-1:0] fetch_data,
  output logic             fetch_valid,
  input  logic             ls_req,
  input  logic             ls_write,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_valid,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             cpu_stall
);
  import mem_arb_pkg::*;

  localparam logic [LAT_BITS-1:0] LAT_INIT = LAT_BITS'(MEM_LATENCY - 1);

  arb_state_t          state, state_nxt;
  logic [LAT_BITS-1:0] cnt, cnt_nxt;
  logic                grant, grant_nxt;
  logic                last_grant, last_grant_nxt;
  logic                we_q;
  logic                pick_ls;
  logic                capture_req;
  logic                capture_rd;

  // Decide which requester would win if granted this cycle.
  always_comb begin
    pick_ls = ls_req;
`ifdef MEM_ARB_RR_EN
    if (ls_req && fetch_req) begin
      pick_ls = (last_grant == GNT_FETCH);
    end
`endif
  end

  // Next-state, counter and grant bookkeeping.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    capture_req    = 1'b0;
    capture_rd     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ls_req || fetch_req) begin
          capture_req = 1'b1;
          grant_nxt   = pick_ls ? GNT_LS : GNT_FETCH;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt   = LAT_INIT;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          capture_rd = 1'b1;
          state_nxt  = ST_DONE;
        end else begin
          cnt_nxt = cnt - LAT_BITS'(1);
        end
      end
      ST_DONE: begin
        last_grant_nxt = grant;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      grant      <= GNT_FETCH;
      last_grant <= GNT_FETCH;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Latch the granted requester's access in IDLE; fetch never writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
    end else if (capture_req) begin
      if (pick_ls) begin
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        we_q      <= ls_write;
      end else begin
        mem_addr  <= fetch_addr;
        mem_wdata <= '0;
        we_q      <= 1'b0;
      end
    end
  end

  // Capture read data on the last WAIT cycle into the granted port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_data <= '0;
      ls_rdata   <= '0;
    end else if (capture_rd) begin
      if (grant == GNT_LS) begin
        ls_rdata <= mem_rdata;
      end else begin
        fetch_data <= mem_rdata;
      end
    end
  end

  assign mem_en      = (state == ST_ISSUE);
  assign mem_we      = mem_en & we_q;
  assign fetch_valid = (state == ST_DONE) & (grant == GNT_FETCH);
  assign ls_valid    = (state == ST_DONE) & (grant == GNT_LS);
  assign cpu_stall   = (fetch_req & ~fetch_valid) | (ls_req & ~ls_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a (MEM_LATENCY=1) and instance b
// (MEM_LATENCY=3), each attached to its own memory model. Expected read data
// comes from a shadow memory kept by the bench; timing expectations come from
// the documented latencies.
module tb_mem_port_arbiter;

  localparam int W     = 16;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         f_req_a = 0, l_req_a = 0, l_write_a = 0;
  logic [W-1:0] f_addr_a = 0, l_addr_a = 0, l_wdata_a = 0;
  logic [W-1:0] f_data_a, l_rdata_a, m_addr_a, m_wdata_a, m_rdata_a;
  logic         f_valid_a, l_valid_a, m_en_a, m_we_a, stall_a;

  logic         f_req_b = 0, l_req_b = 0, l_write_b = 0;
  logic [W-1:0] f_addr_b = 0, l_addr_b = 0, l_wdata_b = 0;
  logic [W-1:0] f_data_b, l_rdata_b, m_addr_b, m_wdata_b, m_rdata_b;
  logic         f_valid_b, l_valid_b, m_en_b, m_we_b, stall_b;

  // preload bus into both memory models
  logic         pl_en = 0;
  logic [7:0]   pl_addr = 0;
  logic [W-1:0] pl_data = 0;

  logic [W-1:0] mem_a [256];
  logic [W-1:0] mem_b [256];
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b [LAT_B];

  logic [W-1:0] exp_mem [256];
  logic [W-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .MEM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(rst),
    .fetch_req(f_req_a), .fetch_addr(f_addr_a), .fetch_data(f_data_a), .fetch_valid(f_valid_a),
    .ls_req(l_req_a), .ls_write(l_write_a), .ls_addr(l_addr_a), .ls_wdata(l_wdata_a),
    .ls_rdata(l_rdata_a), .ls_valid(l_valid_a),
    .mem_en(m_en_a), .mem_we(m_we_a), .mem_addr(m_addr_a), .mem_wdata(m_wdata_a),
    .mem_rdata(m_rdata_a), .cpu_stall(stall_a)
  );

  mem_port_arbiter #(.WIDTH(W), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(rst),
    .fetch_req(f_req_b), .fetch_addr(f_addr_b), .fetch_data(f_data_b), .fetch_valid(f_valid_b),
    .ls_req(l_req_b), .ls_write(l_write_b), .ls_addr(l_addr_b), .ls_wdata(l_wdata_b),
    .ls_rdata(l_rdata_b), .ls_valid(l_valid_b),
    .mem_en(m_en_b), .mem_we(m_we_b), .mem_addr(m_addr_b), .mem_wdata(m_wdata_b),
    .mem_rdata(m_rdata_b), .cpu_stall(stall_b)
  );

  // memory model a: one-cycle read latency, 16'hDEAD when no read returns
  always @(posedge clk) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (m_en_a && m_we_a) mem_a[m_addr_a[7:0]] <= m_wdata_a;
    rd_a <= (m_en_a && !m_we_a) ? mem_a[m_addr_a[7:0]] : 16'hDEAD;
  end
  assign m_rdata_a = rd_a;

  // memory model b: three-cycle read latency
  always @(posedge clk) begin
    if (pl_en) mem_b[pl_addr] <= pl_data;
    else if (m_en_b && m_we_b) mem_b[m_addr_b[7:0]] <= m_wdata_b;
    rd_b[0] <= (m_en_b && !m_we_b) ? mem_b[m_addr_b[7:0]] : 16'hDEAD;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign m_rdata_b = rd_b[LAT_B-1];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    exp_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    f_req_a = 0; l_req_a = 0; f_req_b = 0; l_req_b = 0;
    step(); step();
    rst = 1'b0;
  endtask

  // one uncontended transaction on instance a, checked cycle by cycle
  task automatic do_txn_a(input bit is_fetch, input bit wr, input logic [W-1:0] addr,
                          input logic [W-1:0] wd, input string tag, output logic [W-1:0] rd);
    int exp_lat;
    logic [W-1:0] exp_d;
    exp_lat = wr ? 2 : LAT_A + 2;
    if (wr) exp_mem[addr[7:0]] = wd;
    else exp_q.push_back(exp_mem[addr[7:0]]);
    if (is_fetch) begin
      f_req_a = 1'b1; f_addr_a = addr;
    end else begin
      l_req_a = 1'b1; l_write_a = wr; l_addr_a = addr; l_wdata_a = wd;
    end
    rd = '0;
    for (int c = 0; c <= exp_lat; c++) begin
      #1;
      n_checks++;
      if (stall_a !== (c < exp_lat)) begin
        n_errors++; $display("FAIL %s stall c=%0d: got %b exp %b", tag, c, stall_a, c < exp_lat);
      end
      n_checks++;
      if (m_en_a !== (c == 1)) begin
        n_errors++; $display("FAIL %s mem_en c=%0d: got %b exp %b", tag, c, m_en_a, c == 1);
      end
      if (c == 1) begin
        n_checks++;
        if (m_addr_a !== addr) begin
          n_errors++; $display("FAIL %s mem_addr: got %h exp %h", tag, m_addr_a, addr);
        end
        n_checks++;
        if (m_we_a !== wr) begin
          n_errors++; $display("FAIL %s mem_we: got %b exp %b", tag, m_we_a, wr);
        end
        if (wr) begin
          n_checks++;
          if (m_wdata_a !== wd) begin
            n_errors++; $display("FAIL %s mem_wdata: got %h exp %h", tag, m_wdata_a, wd);
          end
        end
      end
      n_checks++;
      if (f_valid_a !== (is_fetch && c == exp_lat)) begin
        n_errors++; $display("FAIL %s fetch_valid c=%0d: got %b", tag, c, f_valid_a);
      end
      n_checks++;
      if (l_valid_a !== (!is_fetch && c == exp_lat)) begin
        n_errors++; $display("FAIL %s ls_valid c=%0d: got %b", tag, c, l_valid_a);
      end
      if (c == exp_lat && !wr) begin
        exp_d = exp_q.pop_front();
        rd = is_fetch ? f_data_a : l_rdata_a;
        n_checks++;
        if (rd !== exp_d) begin
          n_errors++; $display("FAIL %s rdata: got %h exp %h", tag, rd, exp_d);
        end
      end
      step();
    end
    f_req_a = 1'b0; l_req_a = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [W-1:0] rd;
    rst = 1'b1;
    step(); step();
    n_checks++;
    if ({m_en_a, m_we_a, m_addr_a, m_wdata_a, f_data_a, l_rdata_a, f_valid_a, l_valid_a, stall_a} !== '0) begin
      n_errors++; $display("FAIL reset_a outputs: got %h exp 0",
        {m_en_a, m_we_a, m_addr_a, m_wdata_a, f_data_a, l_rdata_a, f_valid_a, l_valid_a, stall_a});
    end
    n_checks++;
    if ({m_en_b, m_we_b, m_addr_b, m_wdata_b, f_data_b, l_rdata_b, f_valid_b, l_valid_b, stall_b} !== '0) begin
      n_errors++; $display("FAIL reset_b outputs: got %h exp 0",
        {m_en_b, m_we_b, m_addr_b, m_wdata_b, f_data_b, l_rdata_b, f_valid_b, l_valid_b, stall_b});
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) preload(8'(i), 16'(i * 16'h0101) ^ 16'h5A5A);
    // make every output non-zero, then reset in the middle of a store's ISSUE
    preload(8'h50, 16'h9999);
    do_txn_a(1'b1, 1'b0, 16'h0050, 16'h0, "rst_pre_fetch", rd);
    do_txn_a(1'b0, 1'b0, 16'h0050, 16'h0, "rst_pre_load", rd);
    l_req_a = 1'b1; l_write_a = 1'b1; l_addr_a = 16'h0060; l_wdata_a = 16'h4321;
    step();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_en_a, m_we_a, m_addr_a, m_wdata_a, f_data_a, l_rdata_a, f_valid_a, l_valid_a} !== '0) begin
      n_errors++; $display("FAIL async_reset outputs: got %h exp 0",
        {m_en_a, m_we_a, m_addr_a, m_wdata_a, f_data_a, l_rdata_a, f_valid_a, l_valid_a});
    end
    l_req_a = 1'b0; l_write_a = 1'b0;
    #1;
    n_checks++;
    if (stall_a !== 1'b0) begin
      n_errors++; $display("FAIL reset_stall: got %b exp 0", stall_a);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    logic [W-1:0] rd;
    preload(8'h10, 16'hA5A5);
    do_txn_a(1'b1, 1'b0, 16'h0010, 16'h0, "fetch", rd);
    step(); step();
    n_checks++;
    if (f_data_a !== 16'hA5A5) begin
      n_errors++; $display("FAIL fetch_data_hold: got %h exp a5a5", f_data_a);
    end
  endtask

  task automatic test_store();
    logic [W-1:0] rd;
    do_txn_a(1'b0, 1'b1, 16'h0040, 16'h1234, "store", rd);
    step();
    do_txn_a(1'b0, 1'b0, 16'h0040, 16'h0, "store_readback", rd);
    n_checks++;
    if (rd !== 16'h1234) begin
      n_errors++; $display("FAIL store_readback_const: got %h exp 1234", rd);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    preload(8'h20, 16'hBEEF);
    preload(8'h10, 16'hCAFE);
    l_req_a = 1'b1; l_write_a = 1'b0; l_addr_a = 16'h0020;
    f_req_a = 1'b1; f_addr_a = 16'h0010;
    for (int c = 0; c <= 8; c++) begin
      #1;
      n_checks++;
      if (l_valid_a !== (c == 3)) begin
        n_errors++; $display("FAIL contend ls_valid c=%0d: got %b", c, l_valid_a);
      end
      n_checks++;
      if (f_valid_a !== (c == 7)) begin
        n_errors++; $display("FAIL contend fetch_valid c=%0d: got %b", c, f_valid_a);
      end
      n_checks++;
      if (stall_a !== (c < 7)) begin
        n_errors++; $display("FAIL contend stall c=%0d: got %b exp %b", c, stall_a, c < 7);
      end
      if (c == 1 || c == 5) begin
        n_checks++;
        if (m_en_a !== 1'b1 || m_addr_a !== ((c == 1) ? 16'h0020 : 16'h0010)) begin
          n_errors++; $display("FAIL contend issue c=%0d: got en=%b addr=%h", c, m_en_a, m_addr_a);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (l_rdata_a !== 16'hBEEF) begin
          n_errors++; $display("FAIL contend ls_rdata: got %h exp beef", l_rdata_a);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (f_data_a !== 16'hCAFE) begin
          n_errors++; $display("FAIL contend fetch_data: got %h exp cafe", f_data_a);
        end
      end
      step();
      if (c == 3) l_req_a = 1'b0;
      if (c == 7) f_req_a = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rd;
    int kind, gap;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      do_txn_a(kind == 0, kind == 2, 16'($urandom_range(128, 255)), 16'($urandom), "random", rd);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        #1;
        n_checks++;
        if ({m_en_a, f_valid_a, l_valid_a, stall_a} !== 4'b0) begin
          n_errors++; $display("FAIL idle_gap: got %b exp 0000", {m_en_a, f_valid_a, l_valid_a, stall_a});
        end
        step();
      end
    end
  endtask

  task automatic test_grant_order();
    int first, period, g;
    bit exp_ls, exp_v;
    apply_reset();
    preload(8'h11, 16'h1111);
    preload(8'h33, 16'h3333);
    first  = LAT_A + 2;
    period = LAT_A + 3;
    f_req_a = 1'b1; f_addr_a = 16'h0011;
    l_req_a = 1'b1; l_write_a = 1'b0; l_addr_a = 16'h0033;
    for (int c = 0; c <= first + 3 * period; c++) begin
      #1;
      exp_v = (c >= first) && ((c - first) % period == 0);
      g = (c - first) / period;
`ifdef MEM_ARB_RR_EN
      exp_ls = (g % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      n_checks++;
      if (l_valid_a !== (exp_v && exp_ls) || f_valid_a !== (exp_v && !exp_ls)) begin
        n_errors++; $display("FAIL grant_order c=%0d: got ls=%b f=%b exp ls=%b f=%b",
          c, l_valid_a, f_valid_a, exp_v && exp_ls, exp_v && !exp_ls);
      end
      if (exp_v) begin
        n_checks++;
        if (exp_ls ? (l_rdata_a !== 16'h3333) : (f_data_a !== 16'h1111)) begin
          n_errors++; $display("FAIL grant_data g=%0d: got ls=%h f=%h", g, l_rdata_a, f_data_a);
        end
      end
      step();
    end
    f_req_a = 1'b0; l_req_a = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_in_wait();
    preload(8'h20, 16'h7E57);
    l_req_b = 1'b1; l_write_b = 1'b0; l_addr_b = 16'h0020;
    for (int c = 0; c < 3; c++) step();
    // now in the second WAIT cycle
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({l_valid_b, m_en_b, l_rdata_b, m_addr_b} !== '0) begin
      n_errors++; $display("FAIL wait_reset outputs: got %h exp 0", {l_valid_b, m_en_b, l_rdata_b, m_addr_b});
    end
    l_req_b = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if (l_valid_b !== 1'b0 || m_en_b !== 1'b0) begin
        n_errors++; $display("FAIL wait_reset stray: got valid=%b en=%b exp 0", l_valid_b, m_en_b);
      end
      step();
    end
    l_req_b = 1'b1; l_addr_b = 16'h0020;
    for (int c = 0; c <= LAT_B + 2; c++) begin
      #1;
      n_checks++;
      if (l_valid_b !== (c == LAT_B + 2) || m_en_b !== (c == 1) || stall_b !== (c < LAT_B + 2)) begin
        n_errors++; $display("FAIL lat3_load c=%0d: got valid=%b en=%b stall=%b", c, l_valid_b, m_en_b, stall_b);
      end
      if (c == LAT_B + 2) begin
        n_checks++;
        if (l_rdata_b !== 16'h7E57) begin
          n_errors++; $display("FAIL lat3_rdata: got %h exp 7e57", l_rdata_b);
        end
      end
      step();
    end
    l_req_b = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_back_to_back();
    test_grant_order();
    test_reset_in_wait();
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
